// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the single-byte SPI master.
//   - state_t        : transfer FSM states (IDLE, XFER)
//   - DATA_WIDTH_DEF : default bits per transfer
//   - NUM_SLAVES_DEF : default number of chip-select lines
//   - CS_IDLE        : chip-select vector with every slave deselected
package spi_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int NUM_SLAVES_DEF = 3;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  localparam logic [NUM_SLAVES_DEF-1:0] CS_IDLE = {NUM_SLAVES_DEF{1'b1}};

endpackage : spi_pkg

// File: rtl/spi_master.sv
// spi_master: single-byte SPI master, mode 0, LSB first, up to NUM_SLAVES
// slaves selected through active-low chip selects.
//
// Ports:
//   clk                 in   system clock, also the source of sclk
//   reset               in   asynchronous active-high reset
//   start               in   transfer request, sampled on rising clk
//   slaveSelect[1:0]    in   target slave index; out-of-range values ignored
//   masterDataToSend    in   transmit word, captured when a transfer starts
//   masterDataReceived  out  live receive shift register
//   sclk                out  SPI clock, clk gated by the transfer window
//   CS[0:N-1]           out  registered active-low chip selects
//   MOSI                out  serial data to slave (LSB of tx shift register)
//   MISO                in   serial data from slave, sampled on falling clk
//
// Timing (P_k = k-th rising clk edge of a transfer, N_k = falling edge after P_k):
//   P0 load tx / drop CS, P1..P7 shift MOSI, N1..N8 sample MISO, P9 release CS.
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_SLAVES = NUM_SLAVES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            slaveSelect,
  input  logic [DATA_WIDTH-1:0] masterDataToSend,
  output logic [DATA_WIDTH-1:0] masterDataReceived,
  output logic                  sclk,
  output logic [0:NUM_SLAVES-1] CS,
  output logic                  MOSI,
  input  logic                  MISO
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH);
  // Deselect level taken from the package constant, widened to this instance.
  localparam logic [0:NUM_SLAVES-1] CS_OFF = {NUM_SLAVES{CS_IDLE[0]}};

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [0:NUM_SLAVES-1] cs_q, cs_d;
  logic                  sclk_en_q, sclk_en_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic                  sel_valid;

  // Chip-select vector with only the addressed slave driven low.
  function automatic logic [0:NUM_SLAVES-1] cs_select(input logic [1:0] sel);
    logic [0:NUM_SLAVES-1] v;
    v      = CS_OFF;
    v[sel] = 1'b0;
    return v;
  endfunction

  assign sel_valid = ({1'b0, slaveSelect} < 3'(NUM_SLAVES));

  // Next-state logic: FSM, bit counter, tx shift register and chip selects.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    cs_d    = cs_q;
    case (state_q)
      IDLE: begin
        cs_d = CS_OFF;
        if (start && sel_valid) begin
          state_d = XFER;
          cnt_d   = CNT_ZERO;
          tx_d    = masterDataToSend;
          cs_d    = cs_select(slaveSelect);
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (cnt_q == CNT_LAST) begin
          // P9: all bits exchanged, release the slave.
          state_d = IDLE;
          cs_d    = CS_OFF;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          // Only P1..P7 shift; at P8 the last bit stays on MOSI for N8... no,
          // bit 7 is already on MOSI since P7 and simply holds.
          if (cnt_q < (CNT_LAST - CNT_ONE)) begin
            tx_d = {1'b0, tx_q[DATA_WIDTH-1:1]};
          end else begin
            tx_d = tx_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cs_d    = CS_OFF;
      end
    endcase
  end

  // Falling-edge next-state: sclk window enable and MISO shift-in.
  always_comb begin
    sclk_en_d = 1'b0;
    rx_d      = rx_q;
    // Enabled from N0 to N7 so sclk pulses exactly in the high phases after P1..P8.
    if ((state_q == XFER) && (cnt_q != CNT_LAST)) begin
      sclk_en_d = 1'b1;
    end else begin
      sclk_en_d = 1'b0;
    end
    // N0 (counter still zero) precedes the first sclk rise and is skipped.
    if ((state_q == XFER) && (cnt_q != CNT_ZERO)) begin
      rx_d = {MISO, rx_q[DATA_WIDTH-1:1]};
    end else begin
      rx_d = rx_q;
    end
  end

  // Rising-edge registers: FSM state, bit counter, tx shift register, chip selects.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      tx_q    <= {DATA_WIDTH{1'b0}};
      cs_q    <= CS_OFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      cs_q    <= cs_d;
    end
  end

  // Falling-edge registers: sclk enable and receive shift register.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      sclk_en_q <= 1'b0;
      rx_q      <= {DATA_WIDTH{1'b0}};
    end else begin
      sclk_en_q <= sclk_en_d;
      rx_q      <= rx_d;
    end
  end

  // The enable only changes while clk is low, so the gated clock cannot glitch.
  assign sclk               = clk & sclk_en_q;
  assign CS                 = cs_q;
  assign MOSI               = tx_q[0];
  assign masterDataReceived = rx_q;

endmodule : spi_master

// File: tb/tb_spi_master.sv
module tb_spi_master;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] slaveSelect = 2'd0;
  logic [7:0] masterDataToSend = 8'h00;
  logic [7:0] masterDataReceived;
  logic       sclk;
  logic [0:2] CS;
  logic       MOSI;
  logic       MISO = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  spi_master dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .slaveSelect        (slaveSelect),
    .masterDataToSend   (masterDataToSend),
    .masterDataReceived (masterDataReceived),
    .sclk               (sclk),
    .CS                 (CS),
    .MOSI               (MOSI),
    .MISO               (MISO)
  );

  always #5 clk = ~clk;

  // Behavioural slave: drives bit i at the (i+1)-th sclk rise, samples MOSI
  // on the falling clk edges N0..N7 while selected.
  logic       cs_idle;
  logic [7:0] slv_tx = 8'h00;
  logic [7:0] slv_rx = 8'h00;
  logic [3:0] slv_o = 4'd0;
  logic [3:0] slv_i = 4'd0;
  assign cs_idle = &CS;

  always @(posedge sclk or posedge cs_idle) begin
    if (cs_idle) slv_o <= 4'd0;
    else begin
      if (slv_o < 4'd8) MISO <= slv_tx[slv_o[2:0]];
      slv_o <= slv_o + 4'd1;
    end
  end

  always @(negedge clk) begin
    if (cs_idle) slv_i <= 4'd0;
    else if (slv_i < 4'd8) begin
      slv_rx[slv_i[2:0]] <= MOSI;
      slv_i <= slv_i + 4'd1;
    end
  end

  // Monitors: sclk rises, falling edges spent low per CS line, multi-select.
  int sclk_rises = 0;
  int cs_low_cnt [3] = '{0, 0, 0};
  int multi_low = 0;

  always @(posedge sclk) sclk_rises <= sclk_rises + 1;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) if (!CS[k]) cs_low_cnt[k] <= cs_low_cnt[k] + 1;
    if ($countones(~CS) > 1) multi_low <= multi_low + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic kick(input logic [1:0] sel, input logic [7:0] d);
    @(negedge clk);
    start = 1'b1; slaveSelect = sel; masterDataToSend = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (&CS) begin ok = 1'b1; return; end
    end
  endtask

  typedef struct {
    logic [1:0] sel;
    logic [7:0] tx;
    logic [7:0] slv;
    logic [7:0] exp_rx;
    logic [7:0] exp_slv_rx;
  } vec_t;

  vec_t vecs [6];

  task automatic run_vec(input vec_t v, input string tag);
    int s0;
    int c0 [3];
    int lows_other;
    bit ok;
    s0 = sclk_rises;
    for (int k = 0; k < 3; k++) c0[k] = cs_low_cnt[k];
    slv_tx = v.slv;
    kick(v.sel, v.tx);
    wait_idle(ok);
    check({tag, " done"}, 32'(ok), 32'd1);
    check({tag, " rx"}, 32'(masterDataReceived), 32'(v.exp_rx));
    check({tag, " slave_rx"}, 32'(slv_rx), 32'(v.exp_slv_rx));
    check({tag, " sclk_rises"}, 32'(sclk_rises - s0), 32'd8);
    check({tag, " cs_low_cycles"}, 32'(cs_low_cnt[v.sel] - c0[v.sel]), 32'd9);
    lows_other = 0;
    for (int k = 0; k < 3; k++) if (k != int'(v.sel)) lows_other += cs_low_cnt[k] - c0[k];
    check({tag, " cs_others"}, 32'(lows_other), 32'd0);
    @(posedge clk); #1;
    check({tag, " sclk_idle"}, 32'(sclk), 32'd0);
  endtask

  initial begin
    bit ok;
    int s0;
    int c0 [3];

    vecs[0] = '{2'd0, 8'b11010110, 8'b11010011, 8'b11010011, 8'b11010110};
    vecs[1] = '{2'd1, 8'hFF, 8'h00, 8'h00, 8'hFF};
    vecs[2] = '{2'd2, 8'h00, 8'hFF, 8'hFF, 8'h00};
    vecs[3] = '{2'd0, 8'hA5, 8'h5A, 8'h5A, 8'hA5};
    vecs[4] = '{2'd1, 8'h5A, 8'hA5, 8'hA5, 8'h5A};
    vecs[5] = '{2'd2, 8'h3C, 8'h81, 8'h81, 8'h3C};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst CS", 32'(CS), 32'h7);
    check("rst sclk", 32'(sclk), 32'd0);
    check("rst MOSI", 32'(MOSI), 32'd0);
    check("rst rx", 32'(masterDataReceived), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven transfers, back to back
    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Invalid slave index is ignored
    s0 = sclk_rises;
    for (int k = 0; k < 3; k++) c0[k] = cs_low_cnt[k];
    kick(2'd3, 8'h77);
    repeat (12) @(negedge clk);
    check("sel3 sclk", 32'(sclk_rises - s0), 32'd0);
    check("sel3 cs", 32'((cs_low_cnt[0] - c0[0]) + (cs_low_cnt[1] - c0[1]) + (cs_low_cnt[2] - c0[2])), 32'd0);
    check("sel3 CS now", 32'(CS), 32'h7);

    // Start pulsed at P3 with other data/slave is ignored
    for (int k = 0; k < 3; k++) c0[k] = cs_low_cnt[k];
    slv_tx = 8'h96;
    kick(2'd0, 8'h3C);
    repeat (2) @(negedge clk);
    start = 1'b1; slaveSelect = 2'd2; masterDataToSend = 8'hC3;
    @(negedge clk);
    start = 1'b0;
    wait_idle(ok);
    check("busy done", 32'(ok), 32'd1);
    check("busy rx", 32'(masterDataReceived), 32'h96);
    check("busy slave_rx", 32'(slv_rx), 32'h3C);
    check("busy cs0", 32'(cs_low_cnt[0] - c0[0]), 32'd9);
    check("busy cs2", 32'(cs_low_cnt[2] - c0[2]), 32'd0);
    repeat (3) @(negedge clk);
    check("busy no restart", 32'(CS), 32'h7);

    // Start held high across P9 launches a second transfer one edge later
    for (int k = 0; k < 3; k++) c0[k] = cs_low_cnt[k];
    slv_tx = 8'h4B;
    @(negedge clk);
    start = 1'b1; slaveSelect = 2'd1; masterDataToSend = 8'hE1;
    wait_idle(ok);
    check("hold first done", 32'(ok), 32'd1);
    check("hold first rx", 32'(masterDataReceived), 32'h4B);
    check("hold first cs1", 32'(cs_low_cnt[1] - c0[1]), 32'd9);
    slv_tx = 8'h2D;
    masterDataToSend = 8'h17;
    @(negedge clk);
    check("hold restart CS", 32'(CS), 32'h5);
    start = 1'b0;
    wait_idle(ok);
    check("hold second done", 32'(ok), 32'd1);
    check("hold second rx", 32'(masterDataReceived), 32'h2D);
    check("hold second slave_rx", 32'(slv_rx), 32'h17);

    // Async reset between P4 and P5
    slv_tx = 8'hFF;
    kick(2'd2, 8'hFF);
    repeat (4) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("midrst CS", 32'(CS), 32'h7);
    check("midrst sclk", 32'(sclk), 32'd0);
    check("midrst MOSI", 32'(MOSI), 32'd0);
    check("midrst rx", 32'(masterDataReceived), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_vec(vecs[0], "postrst");

    check("single CS low", 32'(multi_low), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_spi_master

// File: doc/spi_master.md
Name: spi_master

Overview:
- Single-byte SPI master, mode 0 (CPOL=0, CPHA=0), LSB first.
- Selects one of three slaves through active-low chip selects.
- Shifts out an 8-bit transmit word on MOSI while shifting in 8 bits from MISO.
- Sits between the system controller (start, slave select, data) and the off-chip SPI pins.

Parameters:
- DATA_WIDTH, 8, bits per transfer.
- NUM_SLAVES, 3, number of chip-select lines.

Ports:
- clk  in  1  system clock; also the source of sclk.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  transfer request, level-sampled on the rising edge of clk.
- slaveSelect  in  2  target slave index, 0..2; value 3 is invalid.
- masterDataToSend  in  8  transmit word, captured at start.
- masterDataReceived  out  8  receive shift register; holds the received byte after a transfer.
- sclk  out  1  SPI clock; idles low.
- CS  out  3 [0:2]  active-low chip selects; CS[i] serves slave i.
- MOSI  out  1  serial data to slave.
- MISO  in  1  serial data from slave.

Behaviour:
- Clocking and reset
  - One clock domain. Uses the rising edge for control and MOSI, and the falling edge only for MISO sampling.
  - Async reset: state=IDLE, CS=3'b111, MOSI=0, sclk=0, masterDataReceived=0, bit counter=0, tx shift register=0.
  - Reset mid-transfer aborts immediately to these values.
- States: IDLE, XFER.
- IDLE
  - CS all high, sclk=0, MOSI holds its last value.
  - At a rising edge P0 with start=1 and slaveSelect<3:
    - drive CS[slaveSelect]=0;
    - load tx shift register = masterDataToSend;
    - MOSI = masterDataToSend[0];
    - counter=0; go to XFER.
  - start with slaveSelect=3 is ignored; stay IDLE.
- XFER
  - sclk = clk; sclk is gated by the XFER state, so 0 outside XFER.
  - slaveSelect and masterDataToSend changes are ignored until the transfer completes.
  - MOSI: at each rising edge P1..P7, shift tx right and set MOSI = next bit. Bit i is valid from P_i to P_(i+1), so the slave samples it at falling edge N_i.
  - MISO: the slave drives bit i at P_(i+1). The master samples at falling edges N1..N8, where N_k is the falling edge after P_k.
    - Each sample does masterDataReceived = {MISO, masterDataReceived[7:1]}.
    - The falling edge N0 before the first sclk rise is not sampled.
  - After N8, masterDataReceived equals the slave's byte (the first received bit lands in bit 0).
  - At P9: CS all high, go to IDLE.
- Busy behaviour: start asserted during XFER is ignored. start still high at P9 starts a new transfer at the next rising edge, not at P9 itself.
- masterDataReceived is the live shift register: it changes during a transfer and holds its value in IDLE until the next transfer.
- CS outputs are registered on the rising edge and glitch-free. At most one CS is low at any time.

Decomposition:
- Shared package spi_pkg:
  - state enum {IDLE, XFER};
  - DATA_WIDTH and NUM_SLAVES defaults;
  - CS_IDLE constant = all ones.
- No sub-module: one FSM, with a rising-edge block (state, counter, tx, CS, MOSI) and a falling-edge block (rx shift).
- Optional small helper: spi_shift_rx (falling-edge 8-bit shift register, enabled in XFER after P1).

Test Plan:
- Basic loopback to behavioural slave 0:
  - Slave byte 8'b11010011, LSB first on each rising edge while CS[0] low; slave samples MOSI on falling edges.
  - masterDataToSend=8'b11010110, slaveSelect=0, start high for one rising edge.
  - Required: masterDataReceived=8'b11010011 after N8; slave has received 8'b11010110; CS returns to 3'b111 at P9.
- Chip-select decode:
  - slaveSelect=1, then 2 → only CS[1], then only CS[2], low for exactly 9 rising-edge periods.
  - slaveSelect=3 with start → CS stays 3'b111, no sclk pulses.
- sclk gating: count sclk rising edges per transfer = 8; sclk=0 in IDLE.
- Async reset mid-transfer:
  - Assert reset between P4 and P5 → CS=3'b111, sclk=0, MOSI=0 and masterDataReceived=0 immediately, without waiting for a clock.
  - A subsequent transfer completes correctly.
- Start while busy:
  - Pulse start at P3 with different data → ignored; current transfer still returns the correct byte.
  - Holding start high across P9 triggers a second transfer.
- Back-to-back patterns: 8'hFF/8'h00 and 8'hA5/8'h5A exchanged on consecutive transfers → each received byte is exact.
